ifu_fetch: RTL and testbench

Instruction fetch unit for the single-cycle `ysyx_22040175` core. Sits directly upstream of the core top: takes the core's `curr_pc`, fetches the instruction over a valid/ready instruction-memory interface, and presents it with a one-cycle `inst_valid` strobe. The core's `ena` is driven from that strobe. Also handles misalignment, bus errors and response timeout, and keeps fetch/stall performance counters.

---
 rtl/ifu_fetch_pkg.sv | 27 ++
 rtl/ifu_fetch_if.sv | 32 +++
 rtl/ifu_perf_cnt.sv | 23 ++
 rtl/ifu_fetch.sv | 91 +++++++++
 tb/tb_ifu_fetch.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_REQ   = 3'd1,
        IFU_WAIT  = 3'd2,
        IFU_VALID = 3'd3,
        IFU_FAULT = 3'd4
    } ifu_state_e;

    typedef enum logic [1:0] {
        IFU_FLT_NONE     = 2'b00,
        IFU_FLT_MISALIGN = 2'b01,
        IFU_FLT_TIMEOUT  = 2'b10,
        IFU_FLT_BUS      = 2'b11
    } ifu_flt_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic logic pc_aligned(
        input logic [1:0] lsb
    );
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response channel.
interface ifu_fetch_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [CPU_WIDTH-1:0] req_addr;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid,
        output req_addr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/ifu_perf_cnt.sv
// Wrapping fetch and stall performance counters.
module ifu_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (fetch_inc)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_inc)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: fetches curr_pc over imem and
// strobes inst_valid for one cycle per retired fetch.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int CPU_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_WIDTH-1:0] curr_pc,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic                 fault,
    output logic [1:0]           fault_code,
    ifu_fetch_if.master          imem,
    output logic [31:0]          fetch_cnt,
    output logic [31:0]          stall_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    ifu_state_e state;
    logic [7:0] wait_cnt;
    logic       aligned;

    assign aligned = pc_aligned(curr_pc[1:0]);

    // The core moves the PC on the VALID edge, so the request
    // must follow curr_pc combinationally while in REQ.
    assign imem.req_valid = (state == IFU_REQ) && aligned;
    assign imem.req_addr  = curr_pc;
    assign imem.rsp_ready = (state == IFU_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IFU_IDLE;
            wait_cnt   <= 8'd0;
            inst       <= INST_NOP;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
            fault_code <= IFU_FLT_NONE;
        end else begin
            inst_valid <= 1'b0;
            unique case (state)
                IFU_IDLE: state <= IFU_REQ;
                IFU_REQ: begin
                    if (!aligned) begin
                        state      <= IFU_FAULT;
                        fault      <= 1'b1;
                        fault_code <= IFU_FLT_MISALIGN;
                    end else if (imem.req_ready) begin
                        state    <= IFU_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                IFU_WAIT: begin
                    if (imem.rsp_valid && imem.rsp_err) begin
                        state      <= IFU_FAULT;
                        fault      <= 1'b1;
                        fault_code <= IFU_FLT_BUS;
                    end else if (imem.rsp_valid) begin
                        inst       <= imem.rsp_data;
                        inst_valid <= 1'b1;
                        state      <= IFU_VALID;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= IFU_FAULT;
                        fault      <= 1'b1;
                        fault_code <= IFU_FLT_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                IFU_VALID: state <= IFU_REQ;
                IFU_FAULT: state <= IFU_FAULT;
                default:   state <= IFU_IDLE;
            endcase
        end
    end

    ifu_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .fetch_inc (state == IFU_VALID),
        .stall_inc ((state == IFU_REQ) ||
                    (state == IFU_WAIT)),
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed timing cases
// plus randomized memory behaviour against a reference model.
module tb_ifu_fetch;

    localparam int TO = 4;

    localparam int M_BOOT  = 0;
    localparam int M_ASK   = 1;
    localparam int M_AWAIT = 2;
    localparam int M_HAND  = 3;
    localparam int M_DEAD  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] curr_pc = 32'h8000_0000;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    ifu_fetch_if #(.CPU_WIDTH(32)) imem ();

    ifu_fetch #(
        .CPU_WIDTH (32),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .curr_pc    (curr_pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fault      (fault),
        .fault_code (fault_code),
        .imem       (imem),
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: what the fetch unit is doing this cycle
    int          m_ph;
    int          m_waited;
    logic [31:0] m_inst;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
    logic [1:0]  m_code;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph     <= M_BOOT;
            m_waited <= 0;
            m_inst   <= 32'h0000_0013;
            m_fetch  <= 32'd0;
            m_stall  <= 32'd0;
            m_code   <= 2'd0;
        end else begin
            case (m_ph)
                M_BOOT: m_ph <= M_ASK;
                M_ASK: begin
                    m_stall <= m_stall + 32'd1;
                    if (curr_pc[1:0] != 2'b00) begin
                        m_ph   <= M_DEAD;
                        m_code <= 2'd1;
                    end else if (imem.req_ready) begin
                        m_ph     <= M_AWAIT;
                        m_waited <= 0;
                    end
                end
                M_AWAIT: begin
                    m_stall <= m_stall + 32'd1;
                    if (imem.rsp_valid && imem.rsp_err) begin
                        m_ph   <= M_DEAD;
                        m_code <= 2'd3;
                    end else if (imem.rsp_valid) begin
                        m_inst <= imem.rsp_data;
                        m_ph   <= M_HAND;
                    end else if (m_waited + 1 >= TO) begin
                        m_ph   <= M_DEAD;
                        m_code <= 2'd2;
                    end else begin
                        m_waited <= m_waited + 1;
                    end
                end
                M_HAND: begin
                    m_fetch <= m_fetch + 32'd1;
                    m_ph    <= M_ASK;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic compare();
        logic exp_rv;
        exp_rv = (m_ph == M_ASK) && (curr_pc[1:0] == 2'b00);
        check("inst_valid", 32'(inst_valid),
              32'(m_ph == M_HAND));
        check("fault", 32'(fault), 32'(m_ph == M_DEAD));
        check("fault_code", 32'(fault_code), 32'(m_code));
        check("inst", inst, m_inst);
        check("req_valid", 32'(imem.req_valid), 32'(exp_rv));
        check("rsp_ready", 32'(imem.rsp_ready),
              32'(m_ph == M_AWAIT));
        if (exp_rv)
            check("req_addr", imem.req_addr, curr_pc);
        check("fetch_cnt", fetch_cnt, m_fetch);
        check("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare();
    endtask

    task automatic drive(input logic rr, input logic rv,
                         input logic er, input logic [31:0] d);
        imem.req_ready = rr;
        imem.rsp_valid = rv;
        imem.rsp_err   = er;
        imem.rsp_data  = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // Zero-wait memory
        curr_pc = 32'h8000_0000;
        do_reset();
        check("lit_rst_inst", inst, 32'h0000_0013);
        check("lit_rst_cnt", fetch_cnt | stall_cnt, 32'd0);
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0010_0093);
            tick();
            if (k + 1 == 3 || k + 1 == 6)
                check("lit_zw_valid", 32'(inst_valid), 32'd1);
            if (k + 1 == 4)
                check("lit_zw_gap", 32'(inst_valid), 32'd0);
            if (k + 1 == 3)
                check("lit_zw_inst", inst, 32'h0010_0093);
        end
        check("lit_zw_fetch", fetch_cnt, 32'd2);
        check("lit_zw_stall", stall_cnt, 32'd4);

        // req_ready low 3 cycles, response 2 cycles late
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(k >= 4, k >= 7, 1'b0, 32'h0020_0113);
            tick();
            if (k + 1 == 7)
                check("lit_st_early", 32'(inst_valid), 32'd0);
            if (k + 1 == 8)
                check("lit_st_valid", 32'(inst_valid), 32'd1);
        end
        check("lit_st_stall", stall_cnt, 32'd7);

        // Misaligned PC
        curr_pc = 32'h8000_0002;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0010_0093);
            tick();
            if (k + 1 == 1)
                check("lit_mis_req", 32'(imem.req_valid), 32'd0);
            if (k + 1 == 2)
                check("lit_mis_code", 32'(fault_code), 32'd1);
        end
        check("lit_mis_novalid", 32'(inst_valid), 32'd0);

        // Bus error after one good fetch
        curr_pc = 32'h8000_0000;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b1, k >= 5,
                  (k >= 5) ? 32'hDEAD_BEEF : 32'h0010_0093);
            tick();
        end
        check("lit_bus_code", 32'(fault_code), 32'd3);
        check("lit_bus_inst", inst, 32'h0010_0093);

        // Timeout, then response on the last WAIT cycle
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            tick();
            if (k + 1 == 5)
                check("lit_to_before", 32'(fault), 32'd0);
        end
        check("lit_to_code", 32'(fault_code), 32'd2);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, k == 5, 1'b0, 32'h0030_0193);
            tick();
        end
        check("lit_to_win", 32'(inst_valid), 32'd1);
        check("lit_to_nofault", 32'(fault), 32'd0);

        // Reset mid-WAIT; late response must be ignored
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'hCAFE_BABE);
        do_reset();
        check("lit_mr_inst", inst, 32'h0000_0013);
        check("lit_mr_cnt", fetch_cnt | stall_cnt, 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'hCAFE_BABE);
            tick();
            if (k + 1 == 1)
                check("lit_mr_req", 32'(imem.req_valid), 32'd1);
        end
        check("lit_mr_ign", inst, 32'h0000_0013);

        // Randomized memory behaviour
        for (int ep = 0; ep < 20; ep++) begin
            curr_pc = 32'h8000_0000 + ($urandom % 1024) * 4;
            do_reset();
            for (int c = 0; c < 300; c++) begin
                if (m_ph == M_DEAD)
                    break;
                if (m_ph == M_HAND) begin
                    curr_pc = 32'h8000_0000 +
                              ($urandom % 1024) * 4;
                    if ($urandom % 50 == 0)
                        curr_pc = curr_pc + 32'd2;
                end
                drive(($urandom % 4) != 0,
                      ($urandom % 3) != 0,
                      ($urandom % 40) == 0,
                      $urandom);
                if ($urandom % 500 == 0)
                    do_reset();
                else
                    tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
